reg_file_param: RTL and testbench
=================================

# reg_file_param

Parametrised multi-port register file for the 32-bit RISC datapath. It is the successor to the fixed 32x32 register file: width and depth are configurable, reads and writes can occur in the same cycle, and a write-first bypass is included. It also adds an optional hardwired zero register and a per-register pending (scoreboard) bit so the decode stage can detect RAW hazards. It sits between decode (read/reserve) and writeback (write/release).

## Interface
- DATA_W, 32, data width of each register
- ADDR_W, 5, address width; depth = 2**ADDR_W
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes, never pending

- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  reset, synchronous, active-high
- rd_en  input  1  capture a new read on both read ports this cycle
- rd_addr1  input  ADDR_W  read port 1 address
- rd_addr2  input  ADDR_W  read port 2 address
- rd_data1  output  DATA_W  registered read data, port 1
- rd_data2  output  DATA_W  registered read data, port 2
- rd_busy1  output  1  registered pending flag of rd_addr1
- rd_busy2  output  1  registered pending flag of rd_addr2
- wr_en  input  1  write enable, from writeback
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- rsv_en  input  1  mark rsv_addr pending (instruction issued with that destination)
- rsv_addr  input  ADDR_W  register to reserve
- pend_any  output  1  OR of all pending bits, registered

## Operation
- Storage: 2**ADDR_W x DATA_W flops plus a 2**ADDR_W-bit pending vector.
- Write: at a clock edge with wr_en=1 and rst=0, mem[wr_addr] <= wr_data. This is independent of rd_en, so a read and a write in the same cycle are both performed.
- Read: at a clock edge with rd_en=1, rd_dataN <= next-state value of mem[rd_addrN] (write-first bypass). If wr_en=1 and wr_addr==rd_addrN in the same cycle, rd_dataN <= wr_data.
- rd_en=0: rd_data1/2 and rd_busy1/2 hold their previous values.
- Pending bit update, per register r:
  - set when rsv_en=1 and rsv_addr=r
  - cleared when wr_en=1 and wr_addr=r
  - when both apply to the same register, set wins, because the newer producer replaces the old one
  - otherwise the bit holds
- rd_busyN: with rd_en=1, rd_busyN <= next-state pending[rd_addrN], giving the same bypass semantics as the data path.
- ZERO_REG=1:
  - writes and reservations to address 0 are ignored
  - reads of address 0 return 0 and busy 0, including when a same-cycle bypass targets address 0
- ZERO_REG=0: address 0 is an ordinary register.
- pend_any <= OR of the next-state pending vector, updated every cycle.

## Timing
- Reset: rst=1 at an edge zeroes all registers, all pending bits, rd_data1/2, rd_busy1/2 and pend_any. Reset dominates every simultaneous rd_en, wr_en and rsv_en. There is no initial-value preload; the post-reset contents are all zero.
- Reset mid-operation discards any in-flight reservation or write in that cycle.
- Read latency is 1 cycle: address presented at edge k, data valid after edge k, usable in cycle k+1.
- Write latency:
  - visible through bypass at the same edge
  - visible through a plain read issued at edge k+1 or later
- Reserve and release take effect at the edge; pend_any reflects the result after the same edge.
- Both read ports may use the same address; both then return identical data.

## Test plan
- Reset then read: rst=1 for 1 cycle, then rd_en=1 with rd_addr1=5, rd_addr2=31 -> rd_data1=0, rd_data2=0, rd_busy1/2=0, pend_any=0.
- Write then read: wr_en=1, wr_addr=7, wr_data=32'hDEADBEEF; next cycle rd_en=1, rd_addr1=7 -> rd_data1=32'hDEADBEEF after one cycle.
- Bypass: in one cycle wr_en=1, wr_addr=3, wr_data=32'h12345678 with rd_en=1, rd_addr1=3, rd_addr2=3 -> both rd_data outputs=32'h12345678 after that edge.
- Scoreboard:
  - rsv_en at addr 9 -> pend_any=1
  - read addr 9 -> rd_busy1=1
  - wr_en to addr 9 with data 32'h55 in the same cycle as a read of 9 -> rd_busy1=0, rd_data1=32'h55, pend_any=0
  - rsv_en and wr_en to addr 4 in the same cycle -> pending[4] stays 1
- Zero register (ZERO_REG=1):
  - write 32'hFFFFFFFF to addr 0, then read addr 0 -> 0
  - rsv_en at addr 0 -> rd_busy=0, pend_any unchanged
- Hold and reset priority:
  - rd_en=0 with changing addresses -> outputs unchanged
  - rst=1 asserted together with wr_en to addr 2 (data 32'hAA) and rsv_en at addr 2 -> mem[2]=0, pending[2]=0

Source files
------------

// File: rtl/reg_file_param_if.sv
// Decode/writeback bundle for the register file: read, write and reserve channels.
// The master side is the pipeline, the slave side is the register file.
interface reg_file_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_busy1;
  logic              rd_busy2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              pend_any;

  modport master (
    output rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data1, rd_data2, rd_busy1, rd_busy2, pend_any
  );

  modport slave (
    input  rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data1, rd_data2, rd_busy1, rd_busy2, pend_any
  );
endinterface

// File: rtl/reg_file_param.sv
// Two-read/one-write register file with write-first bypass and per-register pending bits.
// Reads: 1-cycle registered latency. No backpressure: every port acts on each enabled edge.
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input logic            clk,
  input logic            rst,
  reg_file_param_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
  logic [DATA_W-1:0] rd_data2_q, rd_data2_d;
  logic              rd_busy1_q, rd_busy1_d;
  logic              rd_busy2_q, rd_busy2_d;
  logic              pend_any_q, pend_any_d;

  logic wr_ok;
  logic rsv_ok;
  logic zero1;
  logic zero2;

  // Address 0 is inert when hardwired: no write, no reservation, reads forced to zero.
  assign wr_ok  = bus.wr_en  && !(ZERO_REG && (bus.wr_addr  == '0));
  assign rsv_ok = bus.rsv_en && !(ZERO_REG && (bus.rsv_addr == '0));
  assign zero1  = ZERO_REG && (bus.rd_addr1 == '0);
  assign zero2  = ZERO_REG && (bus.rd_addr2 == '0);

  // Reservation is applied after release so a newer producer keeps the bit set.
  always_comb begin
    pend_d = pend_q;
    if (wr_ok) begin
      pend_d[bus.wr_addr] = 1'b0;
    end
    if (rsv_ok) begin
      pend_d[bus.rsv_addr] = 1'b1;
    end
    pend_any_d = |pend_d;
  end

  always_comb begin
    rd_data1_d = rd_data1_q;
    rd_busy1_d = rd_busy1_q;
    rd_data2_d = rd_data2_q;
    rd_busy2_d = rd_busy2_q;
    if (bus.rd_en) begin
      if (zero1) begin
        rd_data1_d = '0;
        rd_busy1_d = 1'b0;
      end else begin
        rd_data1_d = (wr_ok && (bus.wr_addr == bus.rd_addr1)) ? bus.wr_data
                                                               : mem_q[bus.rd_addr1];
        rd_busy1_d = pend_d[bus.rd_addr1];
      end
      if (zero2) begin
        rd_data2_d = '0;
        rd_busy2_d = 1'b0;
      end else begin
        rd_data2_d = (wr_ok && (bus.wr_addr == bus.rd_addr2)) ? bus.wr_data
                                                               : mem_q[bus.rd_addr2];
        rd_busy2_d = pend_d[bus.rd_addr2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      pend_q     <= '0;
      rd_data1_q <= '0;
      rd_data2_q <= '0;
      rd_busy1_q <= 1'b0;
      rd_busy2_q <= 1'b0;
      pend_any_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem_q[bus.wr_addr] <= bus.wr_data;
      end
      pend_q     <= pend_d;
      rd_data1_q <= rd_data1_d;
      rd_data2_q <= rd_data2_d;
      rd_busy1_q <= rd_busy1_d;
      rd_busy2_q <= rd_busy2_d;
      pend_any_q <= pend_any_d;
    end
  end

  assign bus.rd_data1 = rd_data1_q;
  assign bus.rd_data2 = rd_data2_q;
  assign bus.rd_busy1 = rd_busy1_q;
  assign bus.rd_busy2 = rd_busy2_q;
  assign bus.pend_any = pend_any_q;
endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param (DATA_W=32, ADDR_W=5, ZERO_REG=1) with a behavioural model and scoreboard.
module tb_reg_file_param;
  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
    logic        pa;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_file_param_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  obs_t sb_q[$];

  logic [31:0] m_mem [32];
  logic [31:0] m_pend;
  obs_t        m_out;

  function automatic obs_t sample();
    obs_t o;
    o.d1 = bus.rd_data1;
    o.d2 = bus.rd_data2;
    o.b1 = bus.rd_busy1;
    o.b2 = bus.rd_busy2;
    o.pa = bus.pend_any;
    return o;
  endfunction

  // Drive one cycle, advance the reference model, queue the expected outputs.
  task automatic apply(input logic r, input logic re, input logic [4:0] a1, input logic [4:0] a2,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic rse, input logic [4:0] ra);
    rst = r;
    bus.rd_en = re;  bus.rd_addr1 = a1; bus.rd_addr2 = a2;
    bus.wr_en = we;  bus.wr_addr = wa;  bus.wr_data = wd;
    bus.rsv_en = rse; bus.rsv_addr = ra;
    if (r) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
      m_pend = 32'h0;
      m_out  = '0;
    end else begin
      if (we && wa != 5'd0) begin
        m_mem[wa]  = wd;
        m_pend[wa] = 1'b0;
      end
      if (rse && ra != 5'd0) m_pend[ra] = 1'b1;
      if (re) begin
        m_out.d1 = m_mem[a1];
        m_out.d2 = m_mem[a2];
        m_out.b1 = m_pend[a1];
        m_out.b2 = m_pend[a2];
      end
      m_out.pa = |m_pend;
    end
    sb_q.push_back(m_out);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    apply(1, 1, 5'd7, 5'd7, 1, 5'd7, 32'hAAAA5555, 1, 5'd7);
    got = sample(); exp = sb_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL reset_state got=%h want=%h", got, exp); end
    apply(0, 1, 5'd5, 5'd31, 0, 5'd0, 32'h0, 0, 5'd0);
    got = sample(); exp = sb_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL reset_read got=%h want=%h", got, exp); end
    n_cmp++;
    if (got !== obs_t'(0)) begin n_err++; $display("FAIL reset_read_zero got=%h want=0", got); end
  endtask

  task automatic test_write_read();
    obs_t got, exp;
    apply(0, 0, 5'd0, 5'd0, 1, 5'd7, 32'hDEADBEEF, 0, 5'd0);
    got = sample(); exp = sb_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL write_cycle got=%h want=%h", got, exp); end
    apply(0, 1, 5'd7, 5'd5, 0, 5'd0, 32'h0, 0, 5'd0);
    got = sample(); exp = sb_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL write_then_read got=%h want=%h", got, exp); end
    n_cmp++;
    if (bus.rd_data1 !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL write_then_read_data got=%h want=deadbeef", bus.rd_data1);
    end
  endtask

  task automatic test_bypass();
    obs_t got, exp;
    apply(0, 1, 5'd3, 5'd3, 1, 5'd3, 32'h12345678, 0, 5'd0);
    got = sample(); exp = sb_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL bypass got=%h want=%h", got, exp); end
    n_cmp++;
    if (bus.rd_data1 !== 32'h12345678 || bus.rd_data2 !== 32'h12345678) begin
      n_err++; $display("FAIL bypass_data got=%h/%h want=12345678", bus.rd_data1, bus.rd_data2);
    end
  endtask

  task automatic test_scoreboard();
    obs_t got, exp;
    logic [4:0] a1 [5] = '{5'd0, 5'd9, 5'd9, 5'd4, 5'd4};
    logic [4:0] a2 [5] = '{5'd0, 5'd4, 5'd3, 5'd9, 5'd9};
    logic       re [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       we [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [4:0] wa [5] = '{5'd0, 5'd0, 5'd9, 5'd4, 5'd0};
    logic [31:0] wd [5] = '{32'h0, 32'h0, 32'h55, 32'h66, 32'h0};
    logic       rs [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [4:0] ra [5] = '{5'd9, 5'd0, 5'd0, 5'd4, 5'd0};
    for (int i = 0; i < 5; i++) begin
      apply(0, re[i], a1[i], a2[i], we[i], wa[i], wd[i], rs[i], ra[i]);
      got = sample(); exp = sb_q.pop_front(); n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL scoreboard step%0d got=%h want=%h", i, got, exp); end
    end
    n_cmp++;
    if (bus.rd_busy1 !== 1'b1 || bus.pend_any !== 1'b1) begin
      n_err++; $display("FAIL set_wins got busy=%b pend=%b want 1/1", bus.rd_busy1, bus.pend_any);
    end
    apply(0, 0, 5'd0, 5'd0, 1, 5'd4, 32'h77, 0, 5'd0);
    got = sample(); exp = sb_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL release4 got=%h want=%h", got, exp); end
  endtask

  task automatic test_zero_reg();
    obs_t got, exp;
    apply(0, 0, 5'd0, 5'd0, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0);
    got = sample(); exp = sb_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL zero_write got=%h want=%h", got, exp); end
    apply(0, 1, 5'd0, 5'd7, 0, 5'd0, 32'h0, 1, 5'd0);
    got = sample(); exp = sb_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL zero_read_rsv got=%h want=%h", got, exp); end
    n_cmp++;
    if (bus.rd_data1 !== 32'h0 || bus.rd_busy1 !== 1'b0 || bus.pend_any !== 1'b0) begin
      n_err++; $display("FAIL zero_read_const got d=%h b=%b p=%b want 0/0/0", bus.rd_data1, bus.rd_busy1, bus.pend_any);
    end
    apply(0, 1, 5'd0, 5'd0, 1, 5'd0, 32'hCAFEF00D, 1, 5'd0);
    got = sample(); exp = sb_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL zero_bypass got=%h want=%h", got, exp); end
  endtask

  task automatic test_hold();
    obs_t got, exp;
    apply(0, 1, 5'd7, 5'd3, 0, 5'd0, 32'h0, 1, 5'd12);
    got = sample(); exp = sb_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL hold_setup got=%h want=%h", got, exp); end
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 5'(i + 12), 5'(i * 5), 1, 5'(i + 20), 32'h100 + i, 0, 5'd0);
      got = sample(); exp = sb_q.pop_front(); n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL hold step%0d got=%h want=%h", i, got, exp); end
    end
  endtask

  task automatic test_reset_priority();
    obs_t got, exp;
    apply(0, 0, 5'd0, 5'd0, 1, 5'd2, 32'h11, 0, 5'd0);
    got = sample(); exp = sb_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL rstpri_setup got=%h want=%h", got, exp); end
    apply(1, 1, 5'd2, 5'd2, 1, 5'd2, 32'hAA, 1, 5'd2);
    got = sample(); exp = sb_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL rstpri_reset got=%h want=%h", got, exp); end
    apply(0, 1, 5'd2, 5'd12, 0, 5'd0, 32'h0, 0, 5'd0);
    got = sample(); exp = sb_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL rstpri_read got=%h want=%h", got, exp); end
    n_cmp++;
    if (bus.rd_data1 !== 32'h0 || bus.rd_busy1 !== 1'b0 || bus.pend_any !== 1'b0) begin
      n_err++; $display("FAIL rstpri_const got d=%h b=%b p=%b want 0/0/0", bus.rd_data1, bus.rd_busy1, bus.pend_any);
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, exp;
    int   errs_here = 0;
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 59) == 0), 1'($urandom), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 31)), 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom), 5'($urandom_range(0, 7)));
      got = sample(); exp = sb_q.pop_front(); n_cmp++;
      if (got !== exp) begin
        n_err++; errs_here++;
        if (errs_here <= 5) $display("FAIL back_to_back cyc%0d got=%h want=%h", i, got, exp);
      end
    end
  endtask

  initial begin
    bus.rd_en = 1'b0; bus.rd_addr1 = '0; bus.rd_addr2 = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0;  bus.wr_data = '0;
    bus.rsv_en = 1'b0; bus.rsv_addr = '0;
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    m_pend = 32'h0;
    m_out  = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_zero_reg();
    test_hold();
    test_reset_priority();
    test_back_to_back();
    n_cmp++;
    if (sb_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
